// File: rtl/gpu_pkg.sv
// Shared GPU datapath defaults and the vector load unit FSM encoding.
package gpu_pkg;

  localparam int GPU_LANES      = 4;
  localparam int GPU_DATA_WIDTH = 32;
  localparam int GPU_NUM_VREGS  = 32;

  typedef enum logic [1:0] {
    VLU_IDLE  = 2'd0,
    VLU_LOAD  = 2'd1,
    VLU_WRITE = 2'd2
  } vlu_state_e;

endpackage

// File: rtl/vector_load_unit.sv
// Strided vector load: issues one memory read per lane, gathers the in-order
// responses into a lane buffer, then writes the whole vector to a vreg.
module vector_load_unit
  import gpu_pkg::*;
#(
  parameter int LANES      = GPU_LANES,
  parameter int DATA_WIDTH = GPU_DATA_WIDTH,
  parameter int NUM_VREGS  = GPU_NUM_VREGS
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(NUM_VREGS)-1:0] cmd_vreg_idx,
  input  logic [31:0]                  cmd_base_addr,
  input  logic [31:0]                  cmd_stride,

  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [31:0]                  mem_req_addr,
  output logic                         mem_req_is_write,
  output logic [DATA_WIDTH-1:0]        mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]      mem_req_wstrb,

  input  logic                         mem_resp_valid,
  output logic                         mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]        mem_resp_rdata,

  output logic                         vreg_wr_valid,
  input  logic                         vreg_wr_ready,
  output logic [$clog2(NUM_VREGS)-1:0] vreg_wr_idx,
  output logic [DATA_WIDTH-1:0]        vreg_wr_data [LANES],

  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_VREGS);
  localparam int CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LANES_CNT = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LANES - 1);

  vlu_state_e       state_reg, state_next;
  logic [CNT_W-1:0] req_cnt_reg, req_cnt_next;
  logic [CNT_W-1:0] rsp_cnt_reg, rsp_cnt_next;
  logic [31:0]      addr_reg, addr_next;
  logic [31:0]      stride_reg, stride_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             done_reg, done_next;

  logic cmd_fire;
  logic req_fire;
  logic rsp_fire;
  logic wr_fire;

  // Handshake-side outputs depend only on registered state, never on inputs.
  assign cmd_ready      = (state_reg == VLU_IDLE);
  assign busy           = (state_reg != VLU_IDLE);
  assign mem_req_valid  = (state_reg == VLU_LOAD) && (req_cnt_reg < LANES_CNT);
  assign mem_resp_ready = (state_reg == VLU_LOAD) && (rsp_cnt_reg < req_cnt_reg);
  assign vreg_wr_valid  = (state_reg == VLU_WRITE);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign req_fire = mem_req_valid && mem_req_ready;
  assign rsp_fire = mem_resp_valid && mem_resp_ready;
  assign wr_fire  = vreg_wr_valid && vreg_wr_ready;

  // Address is kept as a running sum so it is stable while a request stalls.
  assign mem_req_addr     = addr_reg;
  assign mem_req_is_write = 1'b0;
  assign mem_req_wdata    = '0;
  assign mem_req_wstrb    = '0;

  assign vreg_wr_idx = idx_reg;
  assign done        = done_reg;

  always_comb begin
    state_next   = state_reg;
    req_cnt_next = req_cnt_reg;
    rsp_cnt_next = rsp_cnt_reg;
    addr_next    = addr_reg;
    stride_next  = stride_reg;
    idx_next     = idx_reg;
    done_next    = 1'b0;

    case (state_reg)
      VLU_IDLE: begin
        if (cmd_fire) begin
          idx_next     = cmd_vreg_idx;
          addr_next    = cmd_base_addr;
          stride_next  = cmd_stride;
          req_cnt_next = '0;
          rsp_cnt_next = '0;
          state_next   = VLU_LOAD;
        end
      end

      VLU_LOAD: begin
        if (req_fire) begin
          req_cnt_next = req_cnt_reg + 1'b1;
          addr_next    = addr_reg + stride_reg;
        end
        if (rsp_fire) begin
          rsp_cnt_next = rsp_cnt_reg + 1'b1;
          if (rsp_cnt_reg == LAST_CNT) begin
            state_next = VLU_WRITE;
          end
        end
      end

      VLU_WRITE: begin
        if (wr_fire) begin
          done_next  = 1'b1;
          state_next = VLU_IDLE;
        end
      end

      default: begin
        state_next = VLU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= VLU_IDLE;
      req_cnt_reg <= '0;
      rsp_cnt_reg <= '0;
      addr_reg    <= '0;
      stride_reg  <= '0;
      idx_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      req_cnt_reg <= req_cnt_next;
      rsp_cnt_reg <= rsp_cnt_next;
      addr_reg    <= addr_next;
      stride_reg  <= stride_next;
      idx_reg     <= idx_next;
      done_reg    <= done_next;
    end
  end

  // Lane buffer: responses arrive in request order, so rsp_cnt selects the lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DATA_WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (rsp_fire && (rsp_cnt_reg == CNT_W'(gi))) begin
        data_reg <= mem_resp_rdata;
      end
    end

    assign vreg_wr_data[gi] = data_reg;
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Self-checking bench for vector_load_unit: a behavioural memory/vreg-port
// driver records each command's traffic, and per-scenario tasks check it.
module tb_vector_load_unit;

  localparam int L  = 4;
  localparam int DW = 32;
  localparam int NV = 32;
  localparam int IW = 5;

  typedef struct {
    int          rel;
    logic [31:0] data;
  } pend_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_vreg_idx;
  logic [31:0]   cmd_base_addr;
  logic [31:0]   cmd_stride;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_req_is_write;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_wstrb;
  logic          mem_resp_valid;
  logic          mem_resp_ready;
  logic [DW-1:0] mem_resp_rdata;
  logic          vreg_wr_valid;
  logic          vreg_wr_ready;
  logic [IW-1:0] vreg_wr_idx;
  logic [DW-1:0] vreg_wr_data [L];
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  vector_load_unit #(.LANES(L), .DATA_WIDTH(DW), .NUM_VREGS(NV)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_vreg_idx(cmd_vreg_idx),
    .cmd_base_addr(cmd_base_addr), .cmd_stride(cmd_stride),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_is_write(mem_req_is_write), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .vreg_wr_valid(vreg_wr_valid), .vreg_wr_ready(vreg_wr_ready), .vreg_wr_idx(vreg_wr_idx),
    .vreg_wr_data(vreg_wr_data), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  // Scenario configuration
  logic [IW-1:0] cfg_idx, cfg_next_idx;
  logic [31:0]   cfg_base, cfg_stride, cfg_next_base, cfg_next_stride;
  logic [31:0]   cfg_data [L];
  int            cfg_lag, cfg_stall_req, cfg_stall_len, cfg_wr_stall, cfg_abort_after;
  bit            cfg_keep_cmd, cfg_pre_acc;

  // Observations from the last command
  logic [31:0]   obs_addr [$];
  logic [31:0]   obs_wr_data [L];
  logic [IW-1:0] obs_wr_idx;
  int            obs_wr_cnt, obs_wr_cycle, obs_done_cycle, obs_hold_viol, obs_const_viol;
  int            obs_busy_viol, obs_early_ready, obs_concurrent;
  bit            obs_ready_at_done, obs_timeout, obs_wr_seen, obs_aborted;

  task automatic set_defaults();
    cfg_lag = 1; cfg_stall_req = -1; cfg_stall_len = 0; cfg_wr_stall = 0;
    cfg_abort_after = -1; cfg_keep_cmd = 0; cfg_pre_acc = 0;
    cfg_next_idx = '0; cfg_next_base = '0; cfg_next_stride = '0;
    for (int k = 0; k < L; k++) cfg_data[k] = $urandom;
  endtask

  // Drives one load command through a behavioural memory and vreg port.
  // Cycle 0 is the cycle in which the command handshake happens.
  task automatic drive_cmd();
    pend_t         pend [$];
    int            t, n_req, n_rsp, stall_left, wr_left;
    bit            accepted, req_hs, rsp_hs, wr_hs, abort_pending;
    bit            prev_req_stalled, prev_wr_stalled;
    logic [31:0]   prev_addr;
    logic [IW-1:0] prev_wr_idx;
    logic [31:0]   prev_wr_data [L];

    obs_addr.delete();
    obs_wr_cnt = 0; obs_wr_cycle = -1; obs_done_cycle = -1; obs_hold_viol = 0;
    obs_const_viol = 0; obs_busy_viol = 0; obs_early_ready = 0; obs_concurrent = 0;
    obs_ready_at_done = 0; obs_timeout = 1; obs_wr_seen = 0; obs_aborted = 0;
    obs_wr_idx = '0;
    for (int k = 0; k < L; k++) begin obs_wr_data[k] = 'x; prev_wr_data[k] = '0; end
    accepted = cfg_pre_acc; t = 0; n_req = 0; n_rsp = 0; abort_pending = 0;
    stall_left = cfg_stall_len; wr_left = cfg_wr_stall;
    prev_req_stalled = 0; prev_wr_stalled = 0; prev_addr = '0; prev_wr_idx = '0;

    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      if (accepted) t++;
      if (mem_req_is_write !== 1'b0 || mem_req_wdata !== '0 || mem_req_wstrb !== '0) obs_const_viol++;
      if (busy !== !cmd_ready) obs_busy_viol++;
      if (prev_req_stalled && (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr)) obs_hold_viol++;
      if (prev_wr_stalled) begin
        if (vreg_wr_valid !== 1'b1 || vreg_wr_idx !== prev_wr_idx) obs_hold_viol++;
        for (int k = 0; k < L; k++) if (vreg_wr_data[k] !== prev_wr_data[k]) obs_hold_viol++;
      end
      if (vreg_wr_valid === 1'b1) obs_wr_seen = 1;

      if (abort_pending) begin
        rst_n = 1'b0; cmd_valid = 1'b0; mem_resp_valid = 1'b0;
        mem_req_ready = 1'b0; vreg_wr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; obs_aborted = 1; obs_timeout = 0;
        $display("cmd idx=%0d base=%h stride=%h aborted by reset after %0d responses",
                 cfg_idx, cfg_base, cfg_stride, n_rsp);
        return;
      end

      if (done === 1'b1 && accepted) begin
        obs_done_cycle = t; obs_ready_at_done = cmd_ready; obs_timeout = 0;
        if (!cfg_keep_cmd) cmd_valid = 1'b0;
        mem_resp_valid = 1'b0; vreg_wr_ready = 1'b0; mem_req_ready = 1'b0;
        $display("cmd idx=%0d base=%h stride=%h reqs=%0d writes=%0d wr_cycle=%0d done_cycle=%0d",
                 cfg_idx, cfg_base, cfg_stride, obs_addr.size(), obs_wr_cnt, obs_wr_cycle, t);
        return;
      end
      if (accepted && t >= 1 && cmd_ready === 1'b1) obs_early_ready++;

      // Command port
      if (!accepted) begin
        cmd_valid = 1'b1; cmd_vreg_idx = cfg_idx; cmd_base_addr = cfg_base; cmd_stride = cfg_stride;
        if (cmd_ready === 1'b1) begin accepted = 1; t = 0; end
      end else if (cfg_keep_cmd) begin
        cmd_valid = 1'b1; cmd_vreg_idx = cfg_next_idx;
        cmd_base_addr = cfg_next_base; cmd_stride = cfg_next_stride;
      end else begin
        cmd_valid = 1'b0;
      end

      // Memory request port
      if (mem_req_valid === 1'b1 && n_req == cfg_stall_req && stall_left > 0) begin
        mem_req_ready = 1'b0; stall_left--;
      end else begin
        mem_req_ready = 1'b1;
      end
      req_hs = (mem_req_valid === 1'b1) && mem_req_ready;
      prev_req_stalled = (mem_req_valid === 1'b1) && !mem_req_ready;
      prev_addr = mem_req_addr;
      if (req_hs) begin
        obs_addr.push_back(mem_req_addr);
        pend.push_back('{t + cfg_lag, (n_req < L) ? cfg_data[n_req] : 32'($urandom)});
        n_req++;
      end

      // Memory response port (in order, after cfg_lag cycles)
      rsp_hs = 0;
      if (pend.size() > 0 && pend[0].rel <= t) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = pend[0].data;
        rsp_hs = (mem_resp_ready === 1'b1);
      end else begin
        mem_resp_valid = 1'b0; mem_resp_rdata = $urandom;
      end
      if (rsp_hs) begin
        void'(pend.pop_front());
        n_rsp++;
        if (cfg_abort_after >= 0 && n_rsp == cfg_abort_after) abort_pending = 1;
      end
      if (req_hs && rsp_hs) obs_concurrent++;

      // Vector register write port
      wr_hs = 0;
      if (vreg_wr_valid === 1'b1) begin
        if (wr_left > 0) begin vreg_wr_ready = 1'b0; wr_left--; end
        else vreg_wr_ready = 1'b1;
        wr_hs = vreg_wr_ready;
      end else begin
        vreg_wr_ready = 1'($urandom_range(0, 1));
      end
      prev_wr_stalled = (vreg_wr_valid === 1'b1) && !vreg_wr_ready;
      prev_wr_idx = vreg_wr_idx;
      for (int k = 0; k < L; k++) prev_wr_data[k] = vreg_wr_data[k];
      if (wr_hs) begin
        obs_wr_cnt++; obs_wr_cycle = t; obs_wr_idx = vreg_wr_idx;
        for (int k = 0; k < L; k++) obs_wr_data[k] = vreg_wr_data[k];
      end
    end
    $display("cmd idx=%0d base=%h stride=%h timed out", cfg_idx, cfg_base, cfg_stride);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_vreg_idx = 5'd7; cmd_base_addr = $urandom;
    cmd_stride = $urandom; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    mem_resp_rdata = $urandom; vreg_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready got=%b exp=0", mem_resp_ready); end
    checks++; if (vreg_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", vreg_wr_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    for (int k = 0; k < L; k++) begin
      checks++; if (vreg_wr_data[k] !== '0) begin errors++; $display("FAIL reset_lane%0d got=%h exp=0", k, vreg_wr_data[k]); end
    end
    // Stray responses while idle must be ignored.
    rst_n = 1'b1; cmd_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_resp_ready !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL idle_resp cycle=%0d resp_ready=%b busy=%b cmd_ready=%b exp 0/0/1", c, mem_resp_ready, busy, cmd_ready);
      end
    end
    mem_resp_valid = 1'b0;
    $display("reset sequence checked");
  endtask

  task automatic test_basic();
    set_defaults();
    cfg_idx = 5'd3; cfg_base = 32'h100; cfg_stride = 32'd4;
    for (int k = 0; k < L; k++) cfg_data[k] = 32'hA0 + 32'(k);
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL basic_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    for (int k = 0; k < L && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL basic_addr%0d got=%h exp=%h", k, obs_addr[k], 32'h100 + 32'(4 * k)); end
    end
    checks++; if (obs_wr_cnt != 1 || obs_wr_idx !== 5'd3) begin errors++; $display("FAIL basic_write got cnt=%0d idx=%0d exp cnt=1 idx=3", obs_wr_cnt, obs_wr_idx); end
    for (int k = 0; k < L; k++) begin
      checks++; if (obs_wr_data[k] !== 32'hA0 + 32'(k)) begin errors++; $display("FAIL basic_lane%0d got=%h exp=%h", k, obs_wr_data[k], 32'hA0 + 32'(k)); end
    end
    checks++; if (obs_wr_cycle != L + 2) begin errors++; $display("FAIL basic_wr_cycle got=%0d exp=%0d", obs_wr_cycle, L + 2); end
    checks++; if (obs_done_cycle != L + 3) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=%0d", obs_done_cycle, L + 3); end
    checks++; if (obs_const_viol != 0 || obs_busy_viol != 0) begin errors++; $display("FAIL basic_const_outputs got viol=%0d/%0d exp=0/0", obs_const_viol, obs_busy_viol); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got done=%b busy=%b exp=0/0", done, busy); end
  endtask

  task automatic test_backpressure();
    set_defaults();
    cfg_idx = 5'd17; cfg_base = 32'h2000_0040; cfg_stride = 32'h10;
    cfg_stall_req = 2; cfg_stall_len = 3; cfg_wr_stall = 5;
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL bp_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    for (int k = 0; k < L && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== cfg_base + 32'(k) * cfg_stride) begin errors++; $display("FAIL bp_addr%0d got=%h exp=%h", k, obs_addr[k], cfg_base + 32'(k) * cfg_stride); end
    end
    checks++; if (obs_hold_viol != 0) begin errors++; $display("FAIL bp_hold_stable got=%0d exp=0", obs_hold_viol); end
    checks++; if (obs_wr_cnt != 1 || obs_wr_idx !== cfg_idx) begin errors++; $display("FAIL bp_write got cnt=%0d idx=%0d exp cnt=1 idx=%0d", obs_wr_cnt, obs_wr_idx, cfg_idx); end
    for (int k = 0; k < L; k++) begin
      checks++; if (obs_wr_data[k] !== cfg_data[k]) begin errors++; $display("FAIL bp_lane%0d got=%h exp=%h", k, obs_wr_data[k], cfg_data[k]); end
    end
    checks++; if (obs_done_cycle != L + 3 + cfg_stall_len + cfg_wr_stall) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=%0d", obs_done_cycle, L + 3 + cfg_stall_len + cfg_wr_stall); end
  endtask

  task automatic test_wrap_and_stride0();
    set_defaults();
    cfg_idx = 5'd9; cfg_base = 32'hFFFF_FFF8; cfg_stride = 32'd8;
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL wrap_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    for (int k = 0; k < L && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 32'hFFFF_FFF8 + 32'(8 * k)) begin errors++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, obs_addr[k], 32'hFFFF_FFF8 + 32'(8 * k)); end
    end
    set_defaults();
    cfg_idx = 5'd31; cfg_base = $urandom; cfg_stride = 32'd0;
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL stride0_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    for (int k = 0; k < L && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== cfg_base) begin errors++; $display("FAIL stride0_addr%0d got=%h exp=%h", k, obs_addr[k], cfg_base); end
    end
    for (int k = 0; k < L; k++) begin
      checks++; if (obs_wr_data[k] !== cfg_data[k]) begin errors++; $display("FAIL stride0_lane%0d got=%h exp=%h", k, obs_wr_data[k], cfg_data[k]); end
    end
  endtask

  task automatic test_overlap();
    set_defaults();
    cfg_idx = 5'd12; cfg_base = 32'h0000_8000; cfg_stride = 32'h40; cfg_lag = 3;
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL ovl_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    checks++; if (obs_concurrent == 0) begin errors++; $display("FAIL ovl_concurrent got=%0d exp>0", obs_concurrent); end
    for (int k = 0; k < L; k++) begin
      checks++; if (obs_wr_data[k] !== cfg_data[k]) begin errors++; $display("FAIL ovl_lane%0d got=%h exp=%h", k, obs_wr_data[k], cfg_data[k]); end
    end
    checks++; if (obs_done_cycle != L + 3 + cfg_lag - 1) begin errors++; $display("FAIL ovl_done_cycle got=%0d exp=%0d", obs_done_cycle, L + 2 + cfg_lag); end
  endtask

  task automatic test_reset_mid_load();
    set_defaults();
    cfg_idx = 5'd4; cfg_base = 32'h300; cfg_stride = 32'd4; cfg_abort_after = 2;
    drive_cmd();
    checks++; if (obs_aborted != 1) begin errors++; $display("FAIL abort_reached got=%0d exp=1", obs_aborted); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%b cmd_ready=%b req_valid=%b exp 0/1/0", busy, cmd_ready, mem_req_valid); end
    repeat (4) begin
      @(negedge clk);
      if (vreg_wr_valid === 1'b1 || done === 1'b1) obs_wr_seen = 1;
    end
    checks++; if (obs_wr_seen != 0) begin errors++; $display("FAIL abort_no_write got=%0d exp=0", obs_wr_seen); end
    set_defaults();
    cfg_idx = 5'd5; cfg_base = 32'h400; cfg_stride = 32'd4;
    drive_cmd();
    checks++; if (obs_wr_cnt != 1 || obs_done_cycle != L + 3) begin errors++; $display("FAIL abort_recover got cnt=%0d done=%0d exp cnt=1 done=%0d", obs_wr_cnt, obs_done_cycle, L + 3); end
    for (int k = 0; k < L; k++) begin
      checks++; if (obs_wr_data[k] !== cfg_data[k]) begin errors++; $display("FAIL abort_recover_lane%0d got=%h exp=%h", k, obs_wr_data[k], cfg_data[k]); end
    end
  endtask

  task automatic test_cmd_hold();
    set_defaults();
    cfg_idx = 5'd1; cfg_base = 32'h1000; cfg_stride = 32'd4; cfg_keep_cmd = 1;
    cfg_next_idx = 5'd2; cfg_next_base = 32'h5000; cfg_next_stride = 32'd12;
    drive_cmd();
    checks++; if (obs_early_ready != 0) begin errors++; $display("FAIL hold_ready_while_busy got=%0d exp=0", obs_early_ready); end
    checks++; if (obs_ready_at_done !== 1'b1) begin errors++; $display("FAIL hold_ready_at_done got=%b exp=1", obs_ready_at_done); end
    set_defaults();
    cfg_idx = 5'd2; cfg_base = 32'h5000; cfg_stride = 32'd12; cfg_pre_acc = 1;
    drive_cmd();
    checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL hold_second_req_count got=%0d exp=%0d", obs_addr.size(), L); end
    for (int k = 0; k < L && k < obs_addr.size(); k++) begin
      checks++; if (obs_addr[k] !== 32'h5000 + 32'(12 * k)) begin errors++; $display("FAIL hold_second_addr%0d got=%h exp=%h", k, obs_addr[k], 32'h5000 + 32'(12 * k)); end
    end
    checks++; if (obs_wr_idx !== 5'd2 || obs_done_cycle != L + 3) begin errors++; $display("FAIL hold_second_write got idx=%0d done=%0d exp idx=2 done=%0d", obs_wr_idx, obs_done_cycle, L + 3); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      set_defaults();
      cfg_idx = 5'($urandom_range(0, NV - 1)); cfg_base = $urandom;
      cfg_stride = (n % 2 == 0) ? 32'($urandom) : 32'($urandom_range(0, 64));
      cfg_lag = $urandom_range(1, 4); cfg_stall_req = $urandom_range(0, L - 1);
      cfg_stall_len = $urandom_range(0, 3); cfg_wr_stall = $urandom_range(0, 3);
      drive_cmd();
      checks++; if (obs_addr.size() != L) begin errors++; $display("FAIL rand%0d_req_count got=%0d exp=%0d", n, obs_addr.size(), L); end
      for (int k = 0; k < L && k < obs_addr.size(); k++) begin
        checks++; if (obs_addr[k] !== cfg_base + 32'(k) * cfg_stride) begin errors++; $display("FAIL rand%0d_addr%0d got=%h exp=%h", n, k, obs_addr[k], cfg_base + 32'(k) * cfg_stride); end
      end
      for (int k = 0; k < L; k++) begin
        checks++; if (obs_wr_data[k] !== cfg_data[k]) begin errors++; $display("FAIL rand%0d_lane%0d got=%h exp=%h", n, k, obs_wr_data[k], cfg_data[k]); end
      end
      checks++; if (obs_wr_cnt != 1 || obs_wr_idx !== cfg_idx || obs_done_cycle != obs_wr_cycle + 1) begin
        errors++; $display("FAIL rand%0d_write got cnt=%0d idx=%0d done=%0d wr=%0d exp cnt=1 idx=%0d done=wr+1", n, obs_wr_cnt, obs_wr_idx, obs_done_cycle, obs_wr_cycle, cfg_idx);
      end
      checks++; if (obs_hold_viol != 0 || obs_const_viol != 0 || obs_timeout) begin errors++; $display("FAIL rand%0d_protocol got hold=%0d const=%0d timeout=%0d exp=0/0/0", n, obs_hold_viol, obs_const_viol, obs_timeout); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_vreg_idx = '0; cmd_base_addr = '0; cmd_stride = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; vreg_wr_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_and_stride0();
    test_overlap();
    test_reset_mid_load();
    test_cmd_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_load_unit.md
VECTOR_LOAD_UNIT -- requirements
Module: vector_load_unit

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 32-bit lanes per vector.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, lane and memory word width.
REQ-003 SHALL have parameter NUM_VREGS, default 32, vector register count; index width $clog2(NUM_VREGS).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  load-command handshake.
REQ-007 cmd_vreg_idx  in  $clog2(NUM_VREGS)  destination vreg.
REQ-008 cmd_base_addr  in  32  byte address of lane 0.
REQ-009 cmd_stride  in  32  byte stride between lanes, unsigned.
REQ-010 mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake.
REQ-011 mem_req_addr  out  32; mem_req_is_write out 1; mem_req_wdata out 32; mem_req_wstrb out 4.
REQ-012 mem_resp_valid / mem_resp_ready  in / out  1 / 1; mem_resp_rdata  in  32.
REQ-013 vreg_wr_valid / vreg_wr_ready  out / in  1 / 1  vector register write handshake.
REQ-014 vreg_wr_idx  out  $clog2(NUM_VREGS); vreg_wr_data  out  DATA_WIDTH x LANES unpacked array.
REQ-015 busy  out  1  state != IDLE; done  out  1  one-cycle pulse on vreg write completion.

Function
REQ-016 FSM states IDLE, LOAD, WRITE; cmd_ready = (state == IDLE).
REQ-017 IDLE: on cmd_valid&&cmd_ready latch idx, base, stride; clear req_cnt, rsp_cnt; next state LOAD.
REQ-018 LOAD: mem_req_valid = (req_cnt < LANES); mem_req_addr = base + req_cnt*stride, modulo 2^32 (wrap, no error).
REQ-019 mem_req_addr held stable while mem_req_valid && !mem_req_ready.
REQ-020 Each request handshake increments req_cnt; address advances by stride.
REQ-021 mem_req_is_write = 0, mem_req_wdata = 0, mem_req_wstrb = 0 at all times.
REQ-022 Up to LANES requests outstanding; responses return in request order, earliest one cycle after their request handshake.
REQ-023 mem_resp_ready = (state == LOAD) && (rsp_cnt < req_cnt); on handshake, rdata stored to lane[rsp_cnt], rsp_cnt increments.
REQ-024 Request and response handshakes in the same cycle both take effect.
REQ-025 Accepting response LANES-1 moves state to WRITE on the next edge.
REQ-026 WRITE: vreg_wr_valid = 1, vreg_wr_idx = latched idx, vreg_wr_data = lane buffer; all held stable until vreg_wr_ready.
REQ-027 On vreg_wr_valid && vreg_wr_ready: done = 1 next cycle only, state to IDLE; a new command is accepted no earlier than that cycle.
REQ-028 Stride 0 is legal: all LANES requests to base address.
REQ-029 Latency with mem_req_ready = 1, one-cycle response, vreg_wr_ready = 1: cmd accepted cycle 0, requests cycles 1..LANES, vreg write cycle LANES+2, done cycle LANES+3.
REQ-030 mem_resp_valid outside LOAD is not accepted (mem_resp_ready = 0) and does not change state.

Reset
REQ-031 rst_n low at a clock edge: state IDLE, req_cnt = rsp_cnt = 0, lane buffer and latched cmd fields = 0, done = 0.
REQ-032 Outputs after reset: cmd_ready 1, busy 0, mem_req_valid 0, mem_resp_ready 0, vreg_wr_valid 0, done 0.
REQ-033 Reset mid-LOAD or mid-WRITE aborts the command; no vreg write is issued for it.

Structure
REQ-034 LANES, DATA_WIDTH, NUM_VREGS defaults and the FSM state enum SHALL live in shared package gpu_pkg.
REQ-035 Single module, no sub-module; address generator and lane buffer inline.

Verification
REQ-036 Basic: base 0x100, stride 4, idx 3, memory returns 0xA0..0xA3 -> requests 0x100,0x104,0x108,0x10C; vreg 3 written {0xA0,0xA1,0xA2,0xA3}; done at cycle 7.
REQ-037 Backpressure: mem_req_ready low 3 cycles on request 2, vreg_wr_ready low 5 cycles -> address and write data held stable, no request duplicated, single write.
REQ-038 Wrap/stride 0: base 0xFFFF_FFF8, stride 8 -> addresses 0xFFFF_FFF8, 0x0, 0x8, 0x10; stride 0 -> four requests to base.
REQ-039 Overlap: responses lag requests by 3 cycles with concurrent request and response handshakes -> lanes stored in order, exactly LANES requests.
REQ-040 Reset mid-LOAD after 2 responses -> IDLE next cycle, vreg_wr_valid never asserted; new command then completes normally.
REQ-041 cmd_valid held during busy -> cmd_ready 0, second command accepted only after done.
